systolic_skew_feeder: RTL and testbench

- Parametrised edge sequencer for an N x N output-stationary systolic array; replaces the hand-written skewed A/B edge sequences for the 3x3 array.
- Holds one N x N A matrix and one N x N B matrix in internal register buffers, loaded word by word.
- On start, streams the diagonally skewed, zero-padded row edges (A) and column edges (B), then waits out the array drain latency.
- Generates the array clear/enable controls and a done pulse.

---
 rtl/systolic_skew_feeder.sv | 146 ++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - skewed A/B edge sequencer for an N x N output-stationary systolic array
module systolic_skew_feeder #(
    parameter int N      = 3,
    parameter int DW     = 32,
    parameter int PE_LAT = 1,
    localparam int AW    = $clog2(N)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_row,
    input  logic [AW-1:0]   wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic            b_transpose,
    input  logic            start,
    output logic [N*DW-1:0] A_out,
    output logic [N*DW-1:0] B_out,
    output logic            ARRAY_EN,
    output logic            CLR,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int FEED_LEN = 3 * N - 2;
    localparam int KW       = $clog2(FEED_LEN);
    localparam int DCW      = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t             state;
    logic [KW-1:0]      k;
    logic [KW-1:0]      k_feed;
    logic [DCW-1:0]     dcnt;
    logic               bt_q;
    logic [DW-1:0]      a_buf [N][N];
    logic [DW-1:0]      b_buf [N][N];
    logic [N*DW-1:0]    feed_a;
    logic [N*DW-1:0]    feed_b;
    int                 kk;

    // Buffers carry no reset; they are only meaningful once written.
    always_ff @(posedge CLK) begin
        if (wr_en && state == S_IDLE && int'(wr_row) < N && int'(wr_col) < N) begin
            if (wr_sel)
                b_buf[wr_row][wr_col] <= wr_data;
            else
                a_buf[wr_row][wr_col] <= wr_data;
        end
    end

    // Edge vectors for the feed step about to be presented.
    assign k_feed = (state == S_CLEAR) ? '0 : k + KW'(1);

    always_comb begin
        feed_a = '0;
        feed_b = '0;
        kk     = int'(k_feed);
        for (int i = 0; i < N; i++) begin
            if (kk >= i && kk - i < N) begin
                feed_a[i*DW +: DW] = a_buf[i][AW'(kk - i)];
                feed_b[i*DW +: DW] = bt_q ? b_buf[i][AW'(kk - i)] : b_buf[AW'(kk - i)][i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            k        <= '0;
            dcnt     <= '0;
            bt_q     <= 1'b0;
            A_out    <= '0;
            B_out    <= '0;
            ARRAY_EN <= 1'b0;
            CLR      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (wr_en && state != S_IDLE)
                err <= 1'b1;
            else if (start && EN && state == S_IDLE)
                err <= 1'b0;

            if (!EN) begin
                ARRAY_EN <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        ARRAY_EN <= 1'b0;
                        CLR      <= 1'b0;
                        done     <= 1'b0;
                        if (start) begin
                            state    <= S_CLEAR;
                            bt_q     <= b_transpose;
                            busy     <= 1'b1;
                            CLR      <= 1'b1;
                            ARRAY_EN <= 1'b1;
                            A_out    <= '0;
                            B_out    <= '0;
                        end
                    end
                    S_CLEAR: begin
                        state    <= S_FEED;
                        k        <= '0;
                        CLR      <= 1'b0;
                        ARRAY_EN <= 1'b1;
                        A_out    <= feed_a;
                        B_out    <= feed_b;
                    end
                    S_FEED: begin
                        ARRAY_EN <= 1'b1;
                        if (k == KW'(FEED_LEN - 1)) begin
                            state <= S_DRAIN;
                            dcnt  <= '0;
                            A_out <= '0;
                            B_out <= '0;
                        end else begin
                            k     <= k + KW'(1);
                            A_out <= feed_a;
                            B_out <= feed_b;
                        end
                    end
                    S_DRAIN: begin
                        ARRAY_EN <= 1'b1;
                        if (dcnt == DCW'(PE_LAT - 1)) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            ARRAY_EN <= 1'b0;
                        end else begin
                            dcnt <= dcnt + DCW'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed testbench for systolic_skew_feeder
module tb_systolic_skew_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, wr_en, wr_sel, b_tr, start;
    logic [1:0]  wr_row, wr_col;
    logic [31:0] wr_data;
    logic [95:0] a_out, b_out;
    logic        array_en, clr, busy, done, err;

    logic        rst4, en4, wr_en4, wr_sel4, b_tr4, start4;
    logic [1:0]  wr_row4, wr_col4;
    logic [15:0] wr_data4;
    logic [63:0] a_out4, b_out4;
    logic        array_en4, clr4, busy4, done4, err4;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_a  [3][7] = '{'{1,2,3,0,0,0,0},    '{0,4,5,6,0,0,0},    '{0,0,7,8,9,0,0}};
    int exp_bn [3][7] = '{'{10,13,16,0,0,0,0}, '{0,11,14,17,0,0,0}, '{0,0,12,15,18,0,0}};
    int exp_bt [3][7] = '{'{10,11,12,0,0,0,0}, '{0,13,14,15,0,0,0}, '{0,0,16,17,18,0,0}};

    systolic_skew_feeder dut (
        .CLK(clk), .RST(rst), .EN(en), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .b_transpose(b_tr), .start(start), .A_out(a_out), .B_out(b_out),
        .ARRAY_EN(array_en), .CLR(clr), .busy(busy), .done(done), .err(err)
    );

    systolic_skew_feeder #(.N(4), .DW(16), .PE_LAT(2)) dut4 (
        .CLK(clk), .RST(rst4), .EN(en4), .wr_en(wr_en4), .wr_sel(wr_sel4),
        .wr_row(wr_row4), .wr_col(wr_col4), .wr_data(wr_data4),
        .b_transpose(b_tr4), .start(start4), .A_out(a_out4), .B_out(b_out4),
        .ARRAY_EN(array_en4), .CLR(clr4), .busy(busy4), .done(done4), .err(err4)
    );

    task automatic write3(input logic sel, input int r, input int c, input int d);
        wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = 32'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write4(input logic sel, input int r, input int c, input int d);
        wr_en4 = 1'b1; wr_sel4 = sel; wr_row4 = 2'(r); wr_col4 = 2'(c); wr_data4 = 16'(d);
        @(negedge clk);
        wr_en4 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst4 = 1'b1; en = 1'b1; en4 = 1'b1; start = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (a_out !== '0) begin n_fail++; $display("FAIL reset_a_out: got %h expected 0", a_out); end
        n_checks++;
        if (b_out !== '0) begin n_fail++; $display("FAIL reset_b_out: got %h expected 0", b_out); end
        n_checks++;
        if ({array_en, clr, busy, done, err} !== 5'b0)
            begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {array_en, clr, busy, done, err}); end
        rst = 1'b0; rst4 = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || clr !== 1'b0) begin n_fail++; $display("FAIL reset_no_run: busy %b clr %b expected 0 0", busy, clr); end
    endtask

    task automatic load3();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                write3(1'b0, i, j, 3*i + j + 1);
                write3(1'b1, i, j, 10 + 3*i + j);
            end
    endtask

    task automatic run_check(input bit bt, input int stall_at, input int stall_len, input bit inject,
                             input int c00, input int c11, input int c22);
        logic [95:0] ea, eb;
        logic [95:0] a_seq [7];
        logic [95:0] b_seq [7];
        int cyc, waitn, cm [3];
        b_tr = bt; start = 1'b1;
        @(negedge clk);
        start = 1'b0; b_tr = ~bt;
        cyc = 1;
        n_checks++;
        if (!(clr === 1'b1 && array_en === 1'b1 && busy === 1'b1 && err === 1'b0 && a_out === '0 && b_out === '0))
            begin n_fail++; $display("FAIL clear_cycle: clr %b en %b busy %b err %b expected 1 1 1 0", clr, array_en, busy, err); end
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); cyc++;
            for (int i = 0; i < 3; i++) begin
                ea[i*32 +: 32] = 32'(exp_a[i][k]);
                eb[i*32 +: 32] = bt ? 32'(exp_bt[i][k]) : 32'(exp_bn[i][k]);
            end
            n_checks++;
            if (a_out !== ea) begin n_fail++; $display("FAIL a_edge k=%0d: got %h expected %h", k, a_out, ea); end
            n_checks++;
            if (b_out !== eb) begin n_fail++; $display("FAIL b_edge k=%0d: got %h expected %h", k, b_out, eb); end
            n_checks++;
            if (array_en !== 1'b1 || clr !== 1'b0)
                begin n_fail++; $display("FAIL feed_ctrl k=%0d: en %b clr %b expected 1 0", k, array_en, clr); end
            a_seq[k] = a_out; b_seq[k] = b_out;
            if (inject && k == 1) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 32'd99; start = 1'b1;
            end
            if (inject && k == 2) begin
                wr_en = 1'b0; start = 1'b0;
                n_checks++;
                if (err !== 1'b1) begin n_fail++; $display("FAIL busy_write_err: got %b expected 1", err); end
            end
            if (k == stall_at) begin
                en = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk); cyc++;
                    n_checks++;
                    if (a_out !== ea || b_out !== eb || array_en !== 1'b0)
                        begin n_fail++; $display("FAIL stall_hold: a %h b %h en %b expected a %h b %h en 0", a_out, b_out, array_en, ea, eb); end
                end
                en = 1'b1;
            end
        end
        waitn = 0;
        while (done !== 1'b1 && waitn < 20) begin
            @(negedge clk); cyc++; waitn++;
            if (done !== 1'b1) begin
                n_checks++;
                if (a_out !== '0 || b_out !== '0 || array_en !== 1'b1)
                    begin n_fail++; $display("FAIL drain: a %h b %h en %b expected 0 0 1", a_out, b_out, array_en); end
            end
        end
        n_checks++;
        if (cyc !== 10 + stall_len) begin n_fail++; $display("FAIL done_latency: got %0d expected %0d", cyc, 10 + stall_len); end
        n_checks++;
        if (busy !== 1'b0 || array_en !== 1'b0 || err !== inject)
            begin n_fail++; $display("FAIL done_state: busy %b en %b err %b expected 0 0 %b", busy, array_en, err, inject); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b expected 0", done); end
        for (int i = 0; i < 3; i++) begin
            cm[i] = 0;
            for (int s = 0; s < 13; s++)
                if (s - i >= 0 && s - i < 7)
                    cm[i] += int'(a_seq[s-i][i*32 +: 32]) * int'(b_seq[s-i][i*32 +: 32]);
        end
        n_checks++;
        if (cm[0] !== c00) begin n_fail++; $display("FAIL c00: got %0d expected %0d", cm[0], c00); end
        n_checks++;
        if (cm[1] !== c11) begin n_fail++; $display("FAIL c11: got %0d expected %0d", cm[1], c11); end
        n_checks++;
        if (cm[2] !== c22) begin n_fail++; $display("FAIL c22: got %0d expected %0d", cm[2], c22); end
    endtask

    task automatic test_start_with_write();
        int waitn;
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd1; wr_col = 2'd1; wr_data = 32'd55;
        b_tr = 1'b0; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_out[32 +: 32] !== 32'd55) begin n_fail++; $display("FAIL start_write_row1: got %0d expected 55", a_out[32 +: 32]); end
        waitn = 0;
        while (done !== 1'b1 && waitn < 20) begin @(negedge clk); waitn++; end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL start_write_done: got %b expected 1", done); end
        @(negedge clk);
        write3(1'b0, 1, 1, 5);
    endtask

    task automatic test_reset_midrun();
        bit saw_done;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (a_out[64 +: 32] !== 32'd9) begin n_fail++; $display("FAIL midrun_k4_row2: got %0d expected 9", a_out[64 +: 32]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (a_out !== '0 || b_out !== '0 || {array_en, clr, busy, done, err} !== 5'b0)
            begin n_fail++; $display("FAIL midrun_reset: a %h b %h ctrl %b expected 0", a_out, b_out, {array_en, clr, busy, done, err}); end
        saw_done = 1'b0;
        repeat (12) begin @(negedge clk); saw_done |= done; end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrun_no_done: got %b expected 0", saw_done); end
    endtask

    task automatic test_n4();
        int cyc, en_cnt;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                write4(1'b0, i, j, 4*i + j + 1);
                write4(1'b1, i, j, 100 + 4*i + j);
            end
        start4 = 1'b1; b_tr4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 1; en_cnt = 0;
        n_checks++;
        if (clr4 !== 1'b1) begin n_fail++; $display("FAIL n4_clear: got %b expected 1", clr4); end
        while (done4 !== 1'b1 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (array_en4 === 1'b1 && clr4 === 1'b0) en_cnt++;
            if (cyc == 5) begin
                n_checks++;
                if (a_out4 !== {16'd13, 16'd10, 16'd7, 16'd4})
                    begin n_fail++; $display("FAIL n4_a_k3: got %h expected %h", a_out4, {16'd13, 16'd10, 16'd7, 16'd4}); end
                n_checks++;
                if (b_out4 !== {16'd103, 16'd106, 16'd109, 16'd112})
                    begin n_fail++; $display("FAIL n4_b_k3: got %h expected %h", b_out4, {16'd103, 16'd106, 16'd109, 16'd112}); end
            end
        end
        n_checks++;
        if (cyc !== 14) begin n_fail++; $display("FAIL n4_latency: got %0d expected 14", cyc); end
        n_checks++;
        if (en_cnt !== 12) begin n_fail++; $display("FAIL n4_enable_cycles: got %0d expected 12", en_cnt); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; b_tr = 1'b0; start = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        rst4 = 1'b1; en4 = 1'b1; wr_en4 = 1'b0; wr_sel4 = 1'b0; b_tr4 = 1'b0; start4 = 1'b0;
        wr_row4 = '0; wr_col4 = '0; wr_data4 = '0;
        test_reset();
        load3();
        run_check(1'b0, -1, 0, 1'b0, 84, 216, 366);
        run_check(1'b1, -1, 0, 1'b0, 68, 212, 410);
        run_check(1'b0, 2, 3, 1'b0, 84, 216, 366);
        run_check(1'b0, -1, 0, 1'b1, 84, 216, 366);
        run_check(1'b0, -1, 0, 1'b0, 84, 216, 366);
        test_start_with_write();
        test_reset_midrun();
        test_n4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
